// File: rtl/board_manager.sv
// Authoritative 8x4 board owner: applies mover results, clears full rows after a
// landing, keeps the score, spawns the next piece and detects game over.
module board_manager (
    input  logic        clka,
    input  logic        reset,
    input  logic        step_valid,
    input  logic        touched,
    input  logic [31:0] new_board_state,
    input  logic [4:0]  new_location,
    input  logic [1:0]  new_rotation,
    output logic [31:0] curr_board_state,
    output logic [1:0]  curr_piece_type,
    output logic [4:0]  curr_piece_location,
    output logic [1:0]  curr_piece_rotation,
    output logic [7:0]  score,
    output logic        busy,
    output logic        game_over,
    output logic [1:0]  state_dbg
);

    // Handshake: a mover result is taken on any edge where step_valid is high and
    // busy is low; busy acts as the inverted ready, and pulses while busy are dropped.
    typedef enum logic [1:0] {IDLE, SCAN, SPAWN, OVER} state_t;

    state_t      state;
    logic [2:0]  row_idx;
    logic [1:0]  next_type;
    logic [31:0] spawn_mask;
    logic [31:0] shifted_board;
    logic        row_full;

    always_comb begin
        spawn_mask = 32'h0000_0020;
        case (next_type)
            2'b00: spawn_mask = 32'h0000_0020;
            2'b01: spawn_mask = 32'h0000_0022;
            2'b10: spawn_mask = 32'h0000_0066;
            2'b11: spawn_mask = 32'h0000_0062;
        endcase
    end

    assign row_full = (curr_board_state[{row_idx, 2'b00} +: 4] == 4'hF);

    // Rows at or above row_idx drop by one; the full row itself is overwritten.
    always_comb begin
        shifted_board = curr_board_state;
        for (int r = 0; r < 8; r++) begin
            if (r == 0)
                shifted_board[3:0] = 4'h0;
            else if (3'(r) <= row_idx)
                shifted_board[r*4 +: 4] = curr_board_state[(r-1)*4 +: 4];
        end
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            curr_board_state    <= 32'h0000_0020;
            curr_piece_type     <= 2'b00;
            curr_piece_location <= 5'd5;
            curr_piece_rotation <= 2'b00;
            next_type           <= 2'b01;
            row_idx             <= 3'd0;
            score               <= 8'd0;
            busy                <= 1'b0;
            game_over           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (step_valid) begin
                        curr_board_state    <= new_board_state;
                        curr_piece_location <= new_location;
                        curr_piece_rotation <= new_rotation;
                        if (touched) begin
                            row_idx <= 3'd7;
                            state   <= SCAN;
                            busy    <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        curr_board_state <= shifted_board;
                        if (score != 8'hFF)
                            score <= score + 8'd1;
                    end else if (row_idx == 3'd0) begin
                        state <= SPAWN;
                    end else begin
                        row_idx <= row_idx - 3'd1;
                    end
                end
                SPAWN: begin
                    if ((curr_board_state & spawn_mask) != 32'h0) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        curr_board_state    <= curr_board_state | spawn_mask;
                        curr_piece_type     <= next_type;
                        curr_piece_location <= 5'd5;
                        curr_piece_rotation <= 2'b00;
                        next_type           <= next_type + 2'b01;
                        state               <= IDLE;
                        busy                <= 1'b0;
                    end
                end
                OVER: begin
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_board_manager.sv
// Directed bench for board_manager: expected results are queued when a step is
// driven and compared once the manager returns to idle or reports game over.
module tb_board_manager;

    logic        clka = 1'b0;
    logic        reset = 1'b0;
    logic        step_valid = 1'b0;
    logic        touched = 1'b0;
    logic [31:0] new_board_state = 32'h0;
    logic [4:0]  new_location = 5'd0;
    logic [1:0]  new_rotation = 2'd0;
    logic [31:0] curr_board_state;
    logic [1:0]  curr_piece_type;
    logic [4:0]  curr_piece_location;
    logic [1:0]  curr_piece_rotation;
    logic [7:0]  score;
    logic        busy;
    logic        game_over;
    logic [1:0]  state_dbg;

    // Packed expectation: {cycles[57:50], go[49], score[48:41], rot[40:39], loc[38:34], type[33:32], board[31:0]}
    localparam int W = 58;
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int failures = 0;
    int busy_cycles;
    int m_score;
    logic [1:0] m_next;
    logic [31:0] masks [4];

    board_manager dut (
        .clka(clka), .reset(reset), .step_valid(step_valid), .touched(touched),
        .new_board_state(new_board_state), .new_location(new_location),
        .new_rotation(new_rotation), .curr_board_state(curr_board_state),
        .curr_piece_type(curr_piece_type), .curr_piece_location(curr_piece_location),
        .curr_piece_rotation(curr_piece_rotation), .score(score), .busy(busy),
        .game_over(game_over), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic apply_reset();
        @(negedge clka);
        reset = 1'b1;
        @(negedge clka);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_board"}, curr_board_state, 32'h0000_0020);
        check({tag, "_type"}, 32'(curr_piece_type), 32'd0);
        check({tag, "_loc"}, 32'(curr_piece_location), 32'd5);
        check({tag, "_rot"}, 32'(curr_piece_rotation), 32'd0);
        check({tag, "_score"}, 32'(score), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_game_over"}, 32'(game_over), 32'd0);
    endtask

    // Driver: one-cycle step pulse; returns on the negedge after the sampling edge.
    task automatic do_step(input logic t, input logic [31:0] b, input logic [4:0] loc,
                           input logic [1:0] rot);
        @(negedge clka);
        step_valid      = 1'b1;
        touched         = t;
        new_board_state = b;
        new_location    = loc;
        new_rotation    = rot;
        @(negedge clka);
        step_valid      = 1'b0;
        touched         = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] b, input logic [1:0] ty, input logic [4:0] loc,
                            input logic [1:0] rot, input logic [7:0] sc, input logic go,
                            input logic [7:0] cyc);
        exp_q.push_back({cyc, go, sc, rot, loc, ty, b});
    endtask

    // Counts busy cycles (bounded) until idle or game over, then scores the outputs.
    task automatic wait_and_check(input string tag);
        logic [W-1:0] e;
        busy_cycles = 0;
        while (busy && !game_over && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clka);
        end
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_cycles"}, 32'(busy_cycles), 32'(e[57:50]));
            check({tag, "_board"}, curr_board_state, e[31:0]);
            check({tag, "_type"}, 32'(curr_piece_type), 32'(e[33:32]));
            check({tag, "_loc"}, 32'(curr_piece_location), 32'(e[38:34]));
            check({tag, "_rot"}, 32'(curr_piece_rotation), 32'(e[40:39]));
            check({tag, "_score"}, 32'(score), 32'(e[48:41]));
            check({tag, "_game_over"}, 32'(game_over), 32'(e[49]));
        end
    endtask

    initial begin
        int k;
        masks[0] = 32'h0000_0020;
        masks[1] = 32'h0000_0022;
        masks[2] = 32'h0000_0066;
        masks[3] = 32'h0000_0062;

        // Reset state
        apply_reset();
        check_reset_values("reset");

        // Non-touched step: one-edge latency, no busy
        push_exp(32'h0000_0200, 2'd0, 5'd9, 2'd1, 8'd0, 1'b0, 8'd0);
        do_step(1'b0, 32'h0000_0200, 5'd9, 2'd1);
        check("plain_busy", 32'(busy), 32'd0);
        wait_and_check("plain");

        // Landing without clears
        apply_reset();
        push_exp(32'h1000_0022, 2'd1, 5'd5, 2'd0, 8'd0, 1'b0, 8'd9);
        do_step(1'b1, 32'h1000_0000, 5'd28, 2'd0);
        wait_and_check("land");

        // Two non-adjacent full rows
        apply_reset();
        push_exp(32'h1000_0022, 2'd1, 5'd5, 2'd0, 8'd2, 1'b0, 8'd11);
        do_step(1'b1, 32'hF1F0_0000, 5'd20, 2'd1);
        wait_and_check("clear2");

        // Spawn overlap -> game over, then a step that must be ignored
        apply_reset();
        push_exp(32'h0000_0024, 2'd0, 5'd5, 2'd0, 8'd0, 1'b1, 8'd9);
        do_step(1'b1, 32'h0000_0024, 5'd5, 2'd0);
        wait_and_check("over");
        push_exp(32'h0000_0024, 2'd0, 5'd5, 2'd0, 8'd0, 1'b1, 8'd0);
        do_step(1'b0, 32'h0000_FFFF, 5'd3, 2'd2);
        wait_and_check("over_hold");
        check("over_busy", 32'(busy), 32'd1);

        // Asynchronous reset in the middle of a scan
        apply_reset();
        do_step(1'b1, 32'hFFFF_0000, 5'd3, 2'd0);
        @(negedge clka);
        @(negedge clka);
        check("midscan_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_values("midscan_reset");
        @(negedge clka);
        reset = 1'b0;

        // Repeated multi-row clears drive the score into saturation
        m_score = 0;
        m_next  = 2'b01;
        for (int i = 0; i < 45; i++) begin
            k = $urandom_range(6, 7);
            m_score = (m_score + k > 255) ? 255 : m_score + k;
            push_exp(masks[m_next], m_next, 5'd5, 2'd0, 8'(m_score), 1'b0, 8'(9 + k));
            do_step(1'b1, 32'hFFFF_FFFF << (4 * (8 - k)), 5'($urandom_range(0, 31)),
                    2'($urandom_range(0, 3)));
            wait_and_check($sformatf("sat%0d", i));
            m_next = m_next + 2'b01;
        end
        check("sat_final", 32'(score), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_manager.md
# board_manager

Owns the authoritative 8x4 board, which is 32 bits with bit index row*4+col, row 0 at the top and row 7 at the bottom. It sits on the opposite side of the piece-movement interface from `move_piece`. Each game tick it drives `curr_board_state` / `curr_piece_*` into the mover and accepts the returned `new_*` / `touched` result. When a piece lands, it clears full rows, updates the score, spawns the next piece, and detects game over.

## Interface
- No parameters. Spawn anchor is fixed at location 5, rotation 00.
- `clka` in 1: single system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `step_valid` in 1: one-cycle pulse, mover result valid this cycle.
- `touched` in 1: piece has landed, qualified by `step_valid`.
- `new_board_state` in 32: board returned by the mover.
- `new_location` in 5: piece anchor returned by the mover.
- `new_rotation` in 2: rotation returned by the mover.
- `curr_board_state` out 32: current board, including the live piece.
- `curr_piece_type` out 2: live piece type.
- `curr_piece_location` out 5: live piece anchor.
- `curr_piece_rotation` out 2: live piece rotation.
- `score` out 8: rows cleared; saturates at 255.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `game_over` out 1: sticky until `reset`.

## Operation
- States: IDLE, SCAN, SPAWN, OVER. Internal registers: `row_idx[2:0]`, `next_type[1:0]`.
- Reset values:
  - state IDLE.
  - `curr_board_state` 32'h0000_0020.
  - `curr_piece_type` 00, `curr_piece_location` 5, `curr_piece_rotation` 00.
  - `next_type` 01.
  - `score` 0, `busy` 0, `game_over` 0.
- IDLE, `step_valid` with `touched`=0: load `curr_board_state`, `curr_piece_location`, `curr_piece_rotation` from `new_*`; stay in IDLE.
- IDLE, `step_valid` with `touched`=1: load the board the same way; `row_idx`=7; go to SCAN.
- SCAN, row `row_idx` full (nibble == 4'hF):
  - In one cycle, rows 1..`row_idx` take the contents of rows 0..`row_idx`-1, and row 0 becomes 0.
  - `score`+1, saturating.
  - `row_idx` is unchanged, so the same row is re-checked next cycle.
- SCAN, row not full: if `row_idx`==0, go to SPAWN; else `row_idx`-1.
- SPAWN: select footprint mask by `next_type` at rotation 00, location 5:
  - type 00: 32'h20.
  - type 01: 32'h22.
  - type 10: 32'h66.
  - type 11: 32'h62.
- SPAWN, `board & mask` != 0: go to OVER, set `game_over`=1. Board and piece outputs are unchanged.
- SPAWN, no overlap:
  - `board |= mask`.
  - `curr_piece_type` = `next_type`, location 5, rotation 00.
  - `next_type` +1, wrapping 11 to 00.
  - Go to IDLE.
- OVER: all outputs hold; `step_valid` is ignored until `reset`.
- `step_valid` is ignored in SCAN, SPAWN and OVER. Upstream must not pulse while `busy`.
- `new_location` / `new_rotation` are captured even when `touched`. They are overwritten at SPAWN.

## Timing
- Non-touched step: outputs update on the edge that samples `step_valid`. Latency is 1 edge and `busy` stays 0.
- Touched step accepted at edge k:
  - SCAN runs edges k+1..k+8+F, where F = number of rows cleared.
  - SPAWN executes at edge k+9+F.
  - `busy` is high for 9+F cycles.
  - New piece outputs and `score` are stable from edge k+9+F onward.
- `score` increments on the same edge that clears the row.
- `reset` asserted in any state, including mid-SCAN: all registers go to their reset values immediately. A partially cleared board is discarded.
- `busy` and `game_over` are registered outputs, with no combinational path from inputs.

## Test plan
- Reset check: assert `reset` → board 32'h0000_0020, type 00, location 5, rotation 00, `score` 0, `busy` 0, `game_over` 0.
- Non-touched step: `step_valid`, `touched`=0, board 32'h0000_0200, location 9, rotation 01 → outputs match after one edge, `busy` never asserts.
- Landing with no clears, from reset: `touched`=1, board 32'h1000_0000, location 28 → `busy` for 9 cycles, then board 32'h1000_0022, type 01, location 5, `score` 0.
- Two non-adjacent full rows, from reset: `touched`=1, board 32'hF1F0_0000 → `busy` for 11 cycles, then board 32'h1000_0022, `score` 2.
- Game over, from reset: `touched`=1, board 32'h0000_0024 → `game_over`=1 after 9 cycles, board stays 32'h0000_0024. A later `step_valid` changes nothing.
- Reset mid-SCAN and score saturation:
  - Assert `reset` 3 cycles after a touched step → reset values on the next sample.
  - Force `score`=255 and clear one row → `score` stays 255.
